// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its neighbours: the memory read port, the
// redirect input from execute, and the instruction stream to decode.
interface fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output mem_addr, mem_rstrb, instr_valid, instr, instr_pc,
    input  mem_rdata, redirect_valid, redirect_addr, instr_ready
  );

  modport slave (
    input  mem_addr, mem_rstrb, instr_valid, instr, instr_pc,
    output mem_rdata, redirect_valid, redirect_addr, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: issues word reads against a 1-cycle memory, tags returned
// words with their PC and queues them for decode; redirects flush everything.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  entry_t        q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          valid, pop, push, issue;
  logic [CW:0]   credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid  = (count != '0);
  assign pop    = valid & bus.instr_ready;
  // Slots already owned (queued + arriving) minus the one leaving this cycle;
  // only issue when the returned word is guaranteed a slot.
  assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue  = !reset && !bus.redirect_valid && (credit < (CW+1)'(DEPTH));
  assign push   = inflight && !bus.redirect_valid;

  assign bus.mem_addr    = fetch_pc;
  assign bus.mem_rstrb   = issue;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? q[head].instr : '0;
  assign bus.instr_pc    = valid ? q[head].pc    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_addr[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{instr: bus.mem_rdata, pc: inflight_pc};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// sequences for PC wrap and asynchronous reset with a full queue.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_ADDR(32'h0000_0000), .DEPTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // 1-cycle registered-read memory
  logic [31:0] rdata_r = '0;
  always_ff @(posedge clk) if (bus.mem_rstrb) rdata_r <= memw(bus.mem_addr);
  assign bus.mem_rdata = rdata_r;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] ra;
    logic        rdy;
    logic        e_rstrb;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic rv, input logic [31:0] ra,
                     input logic rdy, input logic e_rstrb, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.e_rstrb = e_rstrb; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rstrb, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc);
    chk({tag, ".rstrb"}, 32'(bus.mem_rstrb), 32'(e_rstrb));
    chk({tag, ".addr"},  bus.mem_addr, e_addr);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(e_valid));
    chk({tag, ".pc"},    bus.instr_pc, e_pc);
    chk({tag, ".instr"}, bus.instr, e_valid ? memw(e_pc) : 32'h0);
  endtask

  task automatic step(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    reset              = v.rst;
    bus.redirect_valid = v.rv;
    bus.redirect_addr  = v.ra;
    bus.instr_ready    = v.rdy;
    @(negedge clk);
    check_outs(tag, v.e_rstrb, v.e_addr, v.e_valid, v.e_pc);
  endtask

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.instr_ready    = 1'b0;

    // reset state
    add(1, 0, 0, 1, 0, 32'h00, 0, 32'h00);
    // streaming from reset: issue in cycle 0, first valid in cycle 2, no gaps
    for (int k = 0; k < 6; k++)
      add(0, 0, 0, 1, 1, 32'(4 * k), k >= 2, (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);
    add(1, 0, 0, 1, 0, 32'h00, 0, 32'h00);
    // decode stalls from first valid: queue fills with 0x00/0x04, fetch holds at 0x08
    add(0, 0, 0, 0, 1, 32'h00, 0, 32'h00);
    add(0, 0, 0, 0, 1, 32'h04, 0, 32'h00);
    for (int k = 0; k < 10; k++)
      add(0, 0, 0, 0, 0, 32'h08, 1, 32'h00);
    add(0, 0, 0, 1, 1, 32'h08, 1, 32'h00);
    // redirect while 0x04 queued and 0x08 arriving: both dropped
    add(0, 1, 32'h40, 1, 0, 32'h0C, 1, 32'h04);
    add(0, 0, 0,      1, 1, 32'h40, 0, 32'h00);
    add(0, 0, 0,      1, 1, 32'h44, 0, 32'h00);
    // unaligned redirect target is truncated to the word
    add(0, 1, 32'h43, 1, 0, 32'h48, 1, 32'h40);
    add(0, 0, 0,      1, 1, 32'h40, 0, 32'h00);
    add(0, 0, 0,      1, 1, 32'h44, 0, 32'h00);
    add(0, 0, 0,      1, 1, 32'h48, 1, 32'h40);
    // back-to-back redirects: last wins, no strobe during either
    add(0, 1, 32'h80, 1, 0, 32'h4C, 1, 32'h44);
    add(0, 1, 32'hC0, 1, 0, 32'h80, 0, 32'h00);
    add(0, 0, 0,      1, 1, 32'hC0, 0, 32'h00);
    add(0, 0, 0,      1, 1, 32'hC4, 0, 32'h00);
    add(0, 0, 0,      1, 1, 32'hC8, 1, 32'hC0);
    add(0, 0, 0,      1, 1, 32'hCC, 1, 32'hC4);
    // reset with 0xC8 queued and 0xCC in flight; neither may reappear
    add(1, 0, 0,      0, 0, 32'h00, 0, 32'h00);
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 1, 1, 32'(4 * k), k >= 2, (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);

    foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i]);

    // PC wrap across 0xFFFF_FFFC
    step("wrap0", '{0, 1, 32'hFFFF_FFF8, 1, 0, 32'h10, 1, 32'h08});
    step("wrap1", '{0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0});
    step("wrap2", '{0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0});
    step("wrap3", '{0, 0, 0, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8});
    step("wrap4", '{0, 0, 0, 1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC});
    step("wrap5", '{0, 0, 0, 1, 1, 32'h0000_0008, 1, 32'h0000_0000});
    // fill the queue, then hit reset between clock edges
    step("full0", '{0, 0, 0, 0, 0, 32'h0C, 1, 32'h04});
    step("full1", '{0, 0, 0, 0, 0, 32'h0C, 1, 32'h04});
    #2 reset = 1'b1;
    #1 check_outs("async_rst", 0, 32'h00, 0, 32'h00);
    step("rst_hold", '{1, 0, 0, 1, 0, 32'h00, 0, 32'h00});
    step("rel0", '{0, 0, 0, 1, 1, 32'h00, 0, 32'h00});
    step("rel1", '{0, 0, 0, 1, 1, 32'h04, 0, 32'h00});
    step("rel2", '{0, 0, 0, 1, 1, 32'h08, 1, 32'h00});
    step("rel3", '{0, 0, 0, 1, 1, 32'h0C, 1, 32'h04});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
